// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline-control definitions: controller states, the hard-wired zero
// register index and the default performance-counter width.
package hazard_stall_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_ERROR   = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam int         CNT_W_DEF = 32;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Hazard/stall control bundle between the pipeline datapath (master) and the
// stall controller (slave).
interface hazard_stall_unit_if #(
  parameter int CNT_W = hazard_stall_unit_pkg::CNT_W_DEF
);

  logic             memReadEX_i;
  logic             regWriteEX_i;
  logic             subwordLoadEX_i;
  logic [4:0]       writeRegEX_i;
  logic [4:0]       readRegRsID_i;
  logic [4:0]       readRegRtID_i;
  logic             useRsID_i;
  logic             useRtID_i;
  logic             loadHazard_i;
  logic             branchTakenEX_i;
  logic             memBusy_i;
  logic             pcWrite_o;
  logic             ifidWrite_o;
  logic             ifidFlush_o;
  logic             idexBubble_o;
  logic             pipeFreeze_o;
  logic             loadStallFlag_o;
  logic             memTimeout_o;
  logic [CNT_W-1:0] loadStallCnt_o;
  logic [CNT_W-1:0] memStallCnt_o;
  logic [CNT_W-1:0] flushCnt_o;

  modport master (
    output memReadEX_i, regWriteEX_i, subwordLoadEX_i, writeRegEX_i,
           readRegRsID_i, readRegRtID_i, useRsID_i, useRtID_i,
           loadHazard_i, branchTakenEX_i, memBusy_i,
    input  pcWrite_o, ifidWrite_o, ifidFlush_o, idexBubble_o, pipeFreeze_o,
           loadStallFlag_o, memTimeout_o, loadStallCnt_o, memStallCnt_o, flushCnt_o
  );

  modport slave (
    input  memReadEX_i, regWriteEX_i, subwordLoadEX_i, writeRegEX_i,
           readRegRsID_i, readRegRtID_i, useRsID_i, useRtID_i,
           loadHazard_i, branchTakenEX_i, memBusy_i,
    output pcWrite_o, ifidWrite_o, ifidFlush_o, idexBubble_o, pipeFreeze_o,
           loadStallFlag_o, memTimeout_o, loadStallCnt_o, memStallCnt_o, flushCnt_o
  );

endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; clear has priority.
module hazard_stall_unit_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, branch
// squashes, data-memory freeze with watchdog, and saturating stall statistics.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset_i,
  hazard_stall_unit_if.slave  bus
);

  localparam int              WAIT_W      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d, wait_cur;
  logic              flag_q, timeout_q, timeout_set;
  logic              load_use;
  logic              pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze;
  logic              en_load, en_mem, en_flush;

  assign load_use = bus.memReadEX_i && bus.regWriteEX_i && (bus.writeRegEX_i != REG_ZERO) &&
                    (((bus.readRegRsID_i == bus.writeRegEX_i) && bus.useRsID_i) ||
                     ((bus.readRegRtID_i == bus.writeRegEX_i) && bus.useRtID_i));

  // wait_cur is the number of consecutive busy cycles including the current one
  assign wait_cur = wait_q + WAIT_W'(1);

  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    timeout_set = 1'b0;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    en_load     = 1'b0;
    en_mem      = 1'b0;
    en_flush    = 1'b0;
    if (reset_i || (state_q == ST_ERROR)) begin
      pipe_freeze = 1'b1;
    end else if (bus.memBusy_i) begin
      pipe_freeze = 1'b1;
      en_mem      = 1'b1;
      wait_d      = wait_cur;
      if (wait_cur == TIMEOUT_VAL) begin
        state_d     = ST_ERROR;
        timeout_set = 1'b1;
      end else begin
        state_d = ST_MEMWAIT;
      end
    end else begin
      // MEMWAIT leaves in the same cycle memory becomes ready
      state_d = ST_RUN;
      if (bus.branchTakenEX_i) begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        en_flush    = 1'b1;
      end else if (load_use || bus.loadHazard_i) begin
        idex_bubble = 1'b1;
        en_load     = 1'b1;
      end else begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q   <= ST_RUN;
      wait_q    <= '0;
      flag_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (!pipe_freeze) begin
        flag_q <= bus.memReadEX_i && bus.subwordLoadEX_i;
      end
      if (timeout_set) begin
        timeout_q <= 1'b1;
      end
    end
  end

  hazard_stall_unit_sat_counter #(.W(CNT_W)) u_load_cnt (
    .clk (clk), .clr (reset_i), .en (en_load),  .cnt (bus.loadStallCnt_o)
  );

  hazard_stall_unit_sat_counter #(.W(CNT_W)) u_mem_cnt (
    .clk (clk), .clr (reset_i), .en (en_mem),   .cnt (bus.memStallCnt_o)
  );

  hazard_stall_unit_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk), .clr (reset_i), .en (en_flush), .cnt (bus.flushCnt_o)
  );

  assign bus.pcWrite_o       = pc_write;
  assign bus.ifidWrite_o     = ifid_write;
  assign bus.ifidFlush_o     = ifid_flush;
  assign bus.idexBubble_o    = idex_bubble;
  assign bus.pipeFreeze_o    = pipe_freeze;
  assign bus.loadStallFlag_o = flag_q;
  assign bus.memTimeout_o    = timeout_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with a short watchdog and 2-bit counters.
module tb_hazard_stall_unit;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hazard_stall_unit_if #(.CNT_W(2)) bus ();

  hazard_stall_unit #(.CNT_W(2), .MEM_TIMEOUT(4)) dut (
    .clk     (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  task automatic idle();
    bus.memReadEX_i     = 1'b0;
    bus.regWriteEX_i    = 1'b0;
    bus.subwordLoadEX_i = 1'b0;
    bus.writeRegEX_i    = 5'd0;
    bus.readRegRsID_i   = 5'd0;
    bus.readRegRtID_i   = 5'd0;
    bus.useRsID_i       = 1'b0;
    bus.useRtID_i       = 1'b0;
    bus.loadHazard_i    = 1'b0;
    bus.branchTakenEX_i = 1'b0;
    bus.memBusy_i       = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    #1;
    checks++;
    if ({bus.pcWrite_o, bus.ifidWrite_o, bus.pipeFreeze_o, bus.ifidFlush_o, bus.idexBubble_o} !== 5'b00100) begin
      failures++;
      $display("FAIL reset_cycle_outputs got=%b want=00100",
               {bus.pcWrite_o, bus.ifidWrite_o, bus.pipeFreeze_o, bus.ifidFlush_o, bus.idexBubble_o});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.loadStallCnt_o, bus.memStallCnt_o, bus.flushCnt_o, bus.loadStallFlag_o, bus.memTimeout_o} !== 8'd0) begin
      failures++;
      $display("FAIL reset_state got=%b want=0",
               {bus.loadStallCnt_o, bus.memStallCnt_o, bus.flushCnt_o, bus.loadStallFlag_o, bus.memTimeout_o});
    end
    checks++;
    if ({bus.pcWrite_o, bus.ifidWrite_o, bus.pipeFreeze_o} !== 3'b110) begin
      failures++;
      $display("FAIL after_reset_run got=%b want=110", {bus.pcWrite_o, bus.ifidWrite_o, bus.pipeFreeze_o});
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    @(negedge clk);
    bus.memReadEX_i = 1'b1; bus.regWriteEX_i = 1'b1; bus.writeRegEX_i = 5'd8;
    bus.readRegRsID_i = 5'd8; bus.useRsID_i = 1'b1; bus.readRegRtID_i = 5'd9; bus.useRtID_i = 1'b1;
    #1;
    checks++;
    if ({bus.pcWrite_o, bus.ifidWrite_o, bus.idexBubble_o} !== 3'b001) begin
      failures++;
      $display("FAIL load_use_stall got=%b want=001", {bus.pcWrite_o, bus.ifidWrite_o, bus.idexBubble_o});
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (bus.loadStallCnt_o !== 2'd1) begin
      failures++;
      $display("FAIL load_use_count got=%0d want=1", bus.loadStallCnt_o);
    end
  endtask

  task automatic test_subword_load();
    apply_reset();
    @(negedge clk);
    bus.memReadEX_i = 1'b1; bus.regWriteEX_i = 1'b1; bus.subwordLoadEX_i = 1'b1;
    bus.writeRegEX_i = 5'd2; bus.readRegRtID_i = 5'd2; bus.useRtID_i = 1'b1;
    #1;
    checks++;
    if ({bus.pcWrite_o, bus.idexBubble_o} !== 2'b01) begin
      failures++;
      $display("FAIL subword_stall got=%b want=01", {bus.pcWrite_o, bus.idexBubble_o});
    end
    @(negedge clk);
    idle();
    bus.loadHazard_i = 1'b1;
    #1;
    checks++;
    if (bus.loadStallFlag_o !== 1'b1) begin
      failures++;
      $display("FAIL subword_flag got=%b want=1", bus.loadStallFlag_o);
    end
    checks++;
    if ({bus.pcWrite_o, bus.ifidWrite_o, bus.idexBubble_o} !== 3'b001) begin
      failures++;
      $display("FAIL load_hazard_stall got=%b want=001", {bus.pcWrite_o, bus.ifidWrite_o, bus.idexBubble_o});
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if ({bus.loadStallCnt_o, bus.loadStallFlag_o} !== 3'b100) begin
      failures++;
      $display("FAIL subword_count_flag got=%b want=100", {bus.loadStallCnt_o, bus.loadStallFlag_o});
    end
  endtask

  task automatic test_no_stall();
    apply_reset();
    @(negedge clk);
    bus.memReadEX_i = 1'b1; bus.regWriteEX_i = 1'b1; bus.writeRegEX_i = 5'd0;
    bus.readRegRsID_i = 5'd0; bus.useRsID_i = 1'b1;
    #1;
    checks++;
    if ({bus.pcWrite_o, bus.idexBubble_o} !== 2'b10) begin
      failures++;
      $display("FAIL zero_reg_no_stall got=%b want=10", {bus.pcWrite_o, bus.idexBubble_o});
    end
    @(negedge clk);
    bus.writeRegEX_i = 5'd5; bus.readRegRsID_i = 5'd5; bus.useRsID_i = 1'b0;
    bus.readRegRtID_i = 5'd5; bus.useRtID_i = 1'b0;
    #1;
    checks++;
    if ({bus.pcWrite_o, bus.idexBubble_o} !== 2'b10) begin
      failures++;
      $display("FAIL unused_src_no_stall got=%b want=10", {bus.pcWrite_o, bus.idexBubble_o});
    end
    @(negedge clk);
    bus.memReadEX_i = 1'b0; bus.useRsID_i = 1'b1;
    #1;
    checks++;
    if ({bus.pcWrite_o, bus.idexBubble_o} !== 2'b10) begin
      failures++;
      $display("FAIL non_load_no_stall got=%b want=10", {bus.pcWrite_o, bus.idexBubble_o});
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (bus.loadStallCnt_o !== 2'd0) begin
      failures++;
      $display("FAIL no_stall_count got=%0d want=0", bus.loadStallCnt_o);
    end
  endtask

  task automatic test_branch_priority();
    apply_reset();
    @(negedge clk);
    bus.memReadEX_i = 1'b1; bus.regWriteEX_i = 1'b1; bus.writeRegEX_i = 5'd8;
    bus.readRegRsID_i = 5'd8; bus.useRsID_i = 1'b1; bus.branchTakenEX_i = 1'b1;
    #1;
    checks++;
    if ({bus.ifidFlush_o, bus.idexBubble_o, bus.pcWrite_o} !== 3'b111) begin
      failures++;
      $display("FAIL branch_flush got=%b want=111", {bus.ifidFlush_o, bus.idexBubble_o, bus.pcWrite_o});
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if ({bus.flushCnt_o, bus.loadStallCnt_o} !== 4'b0100) begin
      failures++;
      $display("FAIL branch_counts got=%b want=0100", {bus.flushCnt_o, bus.loadStallCnt_o});
    end
  endtask

  task automatic test_mem_wait();
    apply_reset();
    @(negedge clk);
    bus.memReadEX_i = 1'b1; bus.subwordLoadEX_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle();
      bus.memBusy_i = 1'b1;
      #1;
      checks++;
      if ({bus.pipeFreeze_o, bus.pcWrite_o, bus.ifidWrite_o, bus.idexBubble_o} !== 4'b1000) begin
        failures++;
        $display("FAIL busy_freeze_%0d got=%b want=1000", i,
                 {bus.pipeFreeze_o, bus.pcWrite_o, bus.ifidWrite_o, bus.idexBubble_o});
      end
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if ({bus.pipeFreeze_o, bus.pcWrite_o, bus.loadStallFlag_o, bus.memTimeout_o} !== 4'b0110) begin
      failures++;
      $display("FAIL busy_release got=%b want=0110",
               {bus.pipeFreeze_o, bus.pcWrite_o, bus.loadStallFlag_o, bus.memTimeout_o});
    end
    checks++;
    if (bus.memStallCnt_o !== 2'd3) begin
      failures++;
      $display("FAIL mem_stall_count got=%0d want=3", bus.memStallCnt_o);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.memBusy_i = 1'b1;
    end
    @(negedge clk);
    idle();
    bus.branchTakenEX_i = 1'b1;
    #1;
    checks++;
    if ({bus.memTimeout_o, bus.pipeFreeze_o, bus.pcWrite_o, bus.ifidWrite_o, bus.ifidFlush_o} !== 5'b11000) begin
      failures++;
      $display("FAIL timeout_error got=%b want=11000",
               {bus.memTimeout_o, bus.pipeFreeze_o, bus.pcWrite_o, bus.ifidWrite_o, bus.ifidFlush_o});
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if ({bus.flushCnt_o, bus.memTimeout_o, bus.pipeFreeze_o} !== 4'b0011) begin
      failures++;
      $display("FAIL error_hold got=%b want=0011", {bus.flushCnt_o, bus.memTimeout_o, bus.pipeFreeze_o});
    end
  endtask

  task automatic test_reset_recover();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.memTimeout_o, bus.pipeFreeze_o, bus.pcWrite_o, bus.memStallCnt_o} !== 5'b00100) begin
      failures++;
      $display("FAIL error_reset got=%b want=00100",
               {bus.memTimeout_o, bus.pipeFreeze_o, bus.pcWrite_o, bus.memStallCnt_o});
    end
    bus.memBusy_i = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    bus.memBusy_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.pipeFreeze_o, bus.pcWrite_o, bus.memStallCnt_o} !== 4'b0100) begin
      failures++;
      $display("FAIL memwait_reset got=%b want=0100", {bus.pipeFreeze_o, bus.pcWrite_o, bus.memStallCnt_o});
    end
  endtask

  task automatic test_back_to_back_flush();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.branchTakenEX_i = 1'b1;
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (bus.flushCnt_o !== 2'd3) begin
      failures++;
      $display("FAIL flush_saturate got=%0d want=3", bus.flushCnt_o);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    test_reset();
    test_load_use();
    test_subword_load();
    test_no_stall();
    test_branch_priority();
    test_mem_wait();
    test_reset_recover();
    test_back_to_back_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
